// File: rtl/instr_cache_if.sv
// Fetch-side and backing-memory-side signals of the instruction cache.
// slave is the cache's view; master is the view of whatever drives fetch and memory.
interface instr_cache_if;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic [31:0] instr;
  logic        stall;
  logic        invalidate;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output fetch_req, fetch_addr, invalidate, mem_ack, mem_rdata,
    input  instr, stall, mem_req, mem_addr
  );

  modport slave (
    input  fetch_req, fetch_addr, invalidate, mem_ack, mem_rdata,
    output instr, stall, mem_req, mem_addr
  );
endinterface

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache with a zero-latency hit path and an
// in-order line refill FSM over a request/acknowledge memory port.
module instr_cache #(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 4
) (
  input logic          clk,
  input logic          reset,
  instr_cache_if.slave bus
);
  localparam int unsigned OB = $clog2(WORDS);
  localparam int unsigned IB = $clog2(LINES);
  localparam int unsigned TW = 32 - 2 - OB - IB;
  localparam logic [31:0]   Nop      = 32'h0000_0013;
  localparam logic [OB-1:0] LastWord = OB'(WORDS - 1);

  typedef enum logic [0:0] {StIdle, StRefill} state_e;
  state_e state_q, state_d;

  logic [LINES-1:0] valid_q, valid_d;
  logic [OB-1:0]    cnt_q, cnt_d;
  logic             drop_q, drop_d;
  logic [TW-1:0]    tag_lat_q, tag_lat_d;
  logic [IB-1:0]    idx_lat_q, idx_lat_d;

  logic [TW-1:0] tag_q  [LINES];
  logic [31:0]   data_q [LINES*WORDS];

  logic [OB-1:0] f_off;
  logic [IB-1:0] f_idx;
  logic [TW-1:0] f_tag;
  logic          hit, miss, ack, unused_addr_lsb;

  assign f_off           = bus.fetch_addr[2+OB-1:2];
  assign f_idx           = bus.fetch_addr[2+OB+IB-1:2+OB];
  assign f_tag           = bus.fetch_addr[31:2+OB+IB];
  assign unused_addr_lsb = ^bus.fetch_addr[1:0];

  assign hit  = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign miss = bus.fetch_req && !hit;
  assign ack  = (state_q == StRefill) && bus.mem_ack;

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (miss) state_d = StRefill;
      StRefill: if (ack && cnt_q == LastWord) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.instr    = Nop;
    bus.stall    = 1'b0;
    bus.mem_req  = 1'b0;
    bus.mem_addr = '0;
    unique case (state_q)
      StIdle: begin
        if (bus.fetch_req) begin
          if (hit) bus.instr = data_q[{f_idx, f_off}];
          else     bus.stall = 1'b1;
        end
      end
      StRefill: begin
        bus.stall    = 1'b1;
        bus.mem_req  = 1'b1;
        bus.mem_addr = {tag_lat_q, idx_lat_q, cnt_q, 2'b00};
      end
      default: ;
    endcase
  end

  // Invalidate is applied last so it wins over a line completing in the same cycle.
  always_comb begin
    valid_d   = valid_q;
    cnt_d     = cnt_q;
    drop_d    = drop_q;
    tag_lat_d = tag_lat_q;
    idx_lat_d = idx_lat_q;
    if (state_q == StIdle && miss) begin
      tag_lat_d = f_tag;
      idx_lat_d = f_idx;
      cnt_d     = '0;
      drop_d    = 1'b0;
    end
    if (ack) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LastWord && !drop_q) valid_d[idx_lat_q] = 1'b1;
    end
    if (bus.invalidate) begin
      valid_d = '0;
      if (state_q == StRefill) drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= '0;
      cnt_q     <= '0;
      drop_q    <= 1'b0;
      tag_lat_q <= '0;
      idx_lat_q <= '0;
    end else begin
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
      drop_q    <= drop_d;
      tag_lat_q <= tag_lat_d;
      idx_lat_q <= idx_lat_d;
    end
  end

  // Tag and data arrays carry no reset; valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (!reset && ack) begin
      data_q[{idx_lat_q, cnt_q}] <= bus.mem_rdata;
      if (cnt_q == LastWord) tag_q[idx_lat_q] <= tag_lat_q;
    end
  end
endmodule

// File: tb/tb_instr_cache.sv
// Self-checking bench for instr_cache: directed scenarios plus a randomized run
// scored against a line-residency model of a direct-mapped cache.
module tb_instr_cache;
  localparam int unsigned LINES = 16;
  localparam int unsigned WORDS = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   wait_cycles = 0;
  int   wcnt = 0;
  logic [31:0] maddr_q[$];

  instr_cache_if bus ();

  instr_cache #(.LINES(LINES), .WORDS(WORDS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Backing memory: word at address A holds A + 0x1000, acked after wait_cycles idle cycles.
  always @(posedge clk) begin
    if (reset || !bus.mem_req || bus.mem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end
  assign bus.mem_ack   = bus.mem_req && (wcnt == wait_cycles);
  assign bus.mem_rdata = bus.mem_addr + 32'h1000;

  task automatic drive(input logic req, input logic [31:0] addr, input logic inv);
    @(negedge clk);
    bus.fetch_req  = req;
    bus.fetch_addr = addr;
    bus.invalidate = inv;
    #1;
  endtask

  // Holds a fetch until it is served; n = stall cycles seen, got = returned instruction.
  task automatic fetch(input logic [31:0] addr, output int n, output logic [31:0] got);
    n = 0;
    maddr_q.delete();
    drive(1'b1, addr, 1'b0);
    while (bus.stall === 1'b1 && n < 200) begin
      if (bus.mem_req === 1'b1) maddr_q.push_back(bus.mem_addr);
      n++;
      drive(1'b1, addr, 1'b0);
    end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL fetch_timeout addr=%h: still stalled after %0d cycles", addr, n);
    end
    got = bus.instr;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    total++;
    if (bus.stall !== 1'b0 || bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0) begin
      bad++;
      $display("FAIL reset_idle: stall=%b mem_req=%b mem_addr=%h, want 0 0 0",
               bus.stall, bus.mem_req, bus.mem_addr);
    end
    total++;
    if (bus.instr !== NOP) begin
      bad++; $display("FAIL reset_instr: got %h want %h", bus.instr, NOP);
    end
    drive(1'b1, 32'h0, 1'b0);
    total++;
    if (bus.stall !== 1'b1 || bus.instr !== NOP) begin
      bad++;
      $display("FAIL reset_cold_stall: stall=%b instr=%h want 1 %h", bus.stall, bus.instr, NOP);
    end
    drive(1'b0, 32'h0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic test_cold_miss();
    int n;
    logic [31:0] got;
    fetch(32'h0, n, got);
    total++;
    if (n != 5) begin bad++; $display("FAIL cold_penalty: got %0d want 5", n); end
    total++;
    if (got !== 32'h1000) begin bad++; $display("FAIL cold_instr: got %h want 00001000", got); end
    total++;
    if (maddr_q.size() != 4) begin
      bad++; $display("FAIL cold_addr_count: got %0d want 4", maddr_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (maddr_q[i] !== 32'(4 * i)) begin
          bad++; $display("FAIL cold_addr[%0d]: got %h want %h", i, maddr_q[i], 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_line_hits();
    for (int i = 1; i < 4; i++) begin
      drive(1'b1, 32'(4 * i), 1'b0);
      total++;
      if (bus.instr !== 32'h1000 + 32'(4 * i) || bus.stall !== 1'b0 || bus.mem_req !== 1'b0) begin
        bad++;
        $display("FAIL line_hit[%0d]: instr=%h stall=%b mem_req=%b want %h 0 0", i, bus.instr,
                 bus.stall, bus.mem_req, 32'h1000 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_conflict();
    int n;
    logic [31:0] got;
    fetch(32'h100, n, got);
    total++;
    if (n != 5 || got !== 32'h1100) begin
      bad++; $display("FAIL conflict_a: n=%0d instr=%h want 5 00001100", n, got);
    end
    fetch(32'h0, n, got);
    total++;
    if (n != 5 || got !== 32'h1000) begin
      bad++; $display("FAIL conflict_b: n=%0d instr=%h want 5 00001000", n, got);
    end
  endtask

  task automatic test_wait_states();
    int n;
    logic [31:0] got;
    wait_cycles = 2;
    fetch(32'h40, n, got);
    wait_cycles = 0;
    total++;
    if (n != 13 || got !== 32'h1040) begin
      bad++; $display("FAIL wait_miss: n=%0d instr=%h want 13 00001040", n, got);
    end
    total++;
    if (maddr_q.size() != 12) begin
      bad++; $display("FAIL wait_addr_count: got %0d want 12", maddr_q.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        if (maddr_q[i] !== 32'h40 + 32'(4 * (i / 3))) begin
          bad++;
          $display("FAIL wait_addr[%0d]: got %h want %h", i, maddr_q[i], 32'h40 + 32'(4 * (i / 3)));
        end
      end
    end
  endtask

  task automatic test_invalidate_midrefill();
    int n;
    logic [31:0] got;
    drive(1'b1, 32'h80, 1'b0);
    total++;
    if (bus.stall !== 1'b1) begin bad++; $display("FAIL inv_first_miss: stall=%b want 1", bus.stall); end
    for (int w = 0; w < 4; w++) begin
      drive(1'b1, 32'h80, w == 1);
      total++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h80 + 32'(4 * w)) begin
        bad++;
        $display("FAIL inv_refill[%0d]: mem_req=%b mem_addr=%h want 1 %h", w, bus.mem_req,
                 bus.mem_addr, 32'h80 + 32'(4 * w));
      end
    end
    drive(1'b1, 32'h80, 1'b0);
    total++;
    if (bus.stall !== 1'b1 || bus.mem_req !== 1'b0) begin
      bad++;
      $display("FAIL inv_dropped_line: stall=%b mem_req=%b want 1 0", bus.stall, bus.mem_req);
    end
    drive(1'b1, 32'h80, 1'b0);
    total++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h80) begin
      bad++;
      $display("FAIL inv_new_refill: mem_req=%b mem_addr=%h want 1 00000080", bus.mem_req,
               bus.mem_addr);
    end
    fetch(32'h80, n, got);
    total++;
    if (n != 3 || got !== 32'h1080) begin
      bad++; $display("FAIL inv_refetch: n=%0d instr=%h want 3 00001080", n, got);
    end
    fetch(32'h0, n, got);
    total++;
    if (n != 5 || got !== 32'h1000) begin
      bad++; $display("FAIL inv_old_line: n=%0d instr=%h want 5 00001000", n, got);
    end
  endtask

  task automatic test_reset_midrefill();
    int n;
    logic [31:0] got;
    wait_cycles = 2;
    drive(1'b1, 32'h200, 1'b0);
    drive(1'b1, 32'h200, 1'b0);
    total++;
    if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL rst_in_refill: mem_req=%b want 1", bus.mem_req); end
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    reset = 1'b0;
    total++;
    if (bus.mem_req !== 1'b0 || bus.stall !== 1'b0 || bus.mem_addr !== 32'h0) begin
      bad++;
      $display("FAIL rst_abort: mem_req=%b stall=%b mem_addr=%h want 0 0 0", bus.mem_req,
               bus.stall, bus.mem_addr);
    end
    wait_cycles = 0;
    fetch(32'h0, n, got);
    total++;
    if (n != 5 || got !== 32'h1000) begin
      bad++; $display("FAIL rst_lost_line: n=%0d instr=%h want 5 00001000", n, got);
    end
  endtask

  task automatic test_random();
    int resident[LINES];
    int n, w, line, exp_n;
    logic [31:0] addr, got;
    bit is_hit;
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    reset = 1'b0;
    foreach (resident[i]) resident[i] = -1;
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        drive(1'b0, $urandom, 1'b1);
        total++;
        if (bus.stall !== 1'b0) begin bad++; $display("FAIL rnd_inv_idle[%0d]: stall=%b", it, bus.stall); end
        foreach (resident[i]) resident[i] = -1;
      end else begin
        w           = $urandom_range(0, 2);
        wait_cycles = w;
        line        = int'($urandom_range(0, 3)) * LINES + int'($urandom_range(0, LINES - 1));
        addr        = 32'(line * WORDS * 4) + 32'($urandom_range(0, WORDS - 1) * 4)
                      + 32'($urandom_range(0, 3));
        is_hit      = (resident[line % LINES] == line);
        exp_n       = is_hit ? 0 : 1 + int'(WORDS) * (w + 1);
        fetch(addr, n, got);
        total++;
        if (n != exp_n || got !== (addr & 32'hFFFF_FFFC) + 32'h1000) begin
          bad++;
          $display("FAIL rnd_fetch[%0d] addr=%h: n=%0d instr=%h want %0d %h", it, addr, n, got,
                   exp_n, (addr & 32'hFFFF_FFFC) + 32'h1000);
        end
        resident[line % LINES] = line;
      end
    end
    wait_cycles = 0;
  endtask

  initial begin
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = 32'h0;
    bus.invalidate = 1'b0;
    test_reset();
    test_cold_miss();
    test_line_hits();
    test_conflict();
    test_wait_states();
    test_invalidate_midrefill();
    test_reset_midrefill();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
